// File: rtl/proc_scheduler.sv
// -----------------------------------------------------------------------------
// proc_scheduler
//   Round-robin time-slice scheduler for the CPU core's process contexts.
//   Holds the process table (valid bit, MMU start segment, saved PC per slot),
//   counts retired instructions of the running process, requests a context
//   switch at an instruction boundary and then presents the next process to
//   the core.
//
// Ports
//   clka, rst        clock; asynchronous active-high reset
//   slice_len        instructions per slice, sampled at every reload (0 -> 1)
//   retire           one-cycle pulse per retired instruction of running process
//   create_req       request a new process (one request per high cycle)
//   create_segment   MMU start segment of the new process
//   create_pc        start PC of the new process
//   create_ack       one-cycle pulse: slot allocated, index on create_idx
//   create_fail      one-cycle pulse: table full, create_idx holds
//   create_idx       allocated slot index
//   kill_req/idx     invalidate slot kill_idx (ignored if slot already invalid)
//   switch_req       core must stop after its current instruction
//   switch_ack       core at boundary; saved_pc valid in this cycle
//   saved_pc         PC of the outgoing process
//   switch_done      one-cycle pulse: proc_* outputs updated
//   proc_index       running slot
//   proc_segment     start segment of running slot
//   proc_pc          start/resume PC of running slot
//   run              a process is scheduled
// -----------------------------------------------------------------------------
module proc_scheduler #(
    parameter int NPROC         = 8,
    parameter int IDX_W         = 3,
    parameter int SLICE_W       = 8,
    parameter int SLICE_DEFAULT = 16
) (
    input  logic               clka,
    input  logic               rst,
    input  logic [SLICE_W-1:0] slice_len,
    input  logic               retire,
    input  logic               create_req,
    input  logic [15:0]        create_segment,
    input  logic [9:0]         create_pc,
    output logic               create_ack,
    output logic               create_fail,
    output logic [IDX_W-1:0]   create_idx,
    input  logic               kill_req,
    input  logic [IDX_W-1:0]   kill_idx,
    output logic               switch_req,
    input  logic               switch_ack,
    input  logic [9:0]         saved_pc,
    output logic               switch_done,
    output logic [IDX_W-1:0]   proc_index,
    output logic [15:0]        proc_segment,
    output logic [9:0]         proc_pc,
    output logic               run
);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_SELECT,
        S_IDLE
    } state_t;

    state_t state, state_nx;

    // process table
    logic [NPROC-1:0] valid;
    logic [15:0]      seg_tbl [NPROC];
    logic [9:0]       pc_tbl  [NPROC];

    logic [SLICE_W-1:0] counter, counter_nx, reload_len;

    // next-state values of registered outputs
    logic               switch_req_nx, switch_done_nx, run_nx;
    logic [IDX_W-1:0]   pidx_nx;
    logic [15:0]        pseg_nx;
    logic [9:0]         ppc_nx;
    logic               create_ack_nx, create_fail_nx;
    logic [IDX_W-1:0]   create_idx_nx;
    logic               pc_wb;

    // helper signals
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               kill_hit, kill_cur;
    logic [NPROC-1:0]   cur_onehot, kill_mask, valid_sel;
    logic               others_valid;
    logic               next_found;
    logic [IDX_W-1:0]   next_idx, cand;

    assign reload_len   = (slice_len == '0) ? SLICE_W'(1) : slice_len;
    assign kill_hit     = kill_req && valid[kill_idx];
    assign kill_cur     = kill_hit && (kill_idx == proc_index);
    assign cur_onehot   = NPROC'(1) << proc_index;
    assign kill_mask    = kill_hit ? (NPROC'(1) << kill_idx) : '0;
    assign others_valid = |(valid & ~cur_onehot);
    // a slot killed while SELECT is evaluating must not be picked
    assign valid_sel    = valid & ~kill_mask;

    // lowest-index free slot, from the table state at the start of the cycle
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < NPROC; i++) begin
            if (!free_found && !valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // round-robin search: proc_index+1 ... wrapping, ending with proc_index
    always_comb begin
        next_found = 1'b0;
        next_idx   = proc_index;
        cand       = proc_index;
        for (int unsigned i = 1; i <= NPROC; i++) begin
            cand = IDX_W'(32'(proc_index) + i);
            if (!next_found && valid_sel[cand]) begin
                next_found = 1'b1;
                next_idx   = cand;
            end
        end
    end

    // create response
    always_comb begin
        create_ack_nx  = create_req && free_found;
        create_fail_nx = create_req && !free_found;
        create_idx_nx  = (create_req && free_found) ? free_idx : create_idx;
    end

    // next-state and output logic
    always_comb begin
        state_nx       = state;
        counter_nx     = counter;
        switch_req_nx  = switch_req;
        switch_done_nx = 1'b0;
        run_nx         = run;
        pidx_nx        = proc_index;
        pseg_nx        = proc_segment;
        ppc_nx         = proc_pc;
        pc_wb          = 1'b0;

        case (state)
            S_RUN: begin
                if (kill_cur) begin
                    switch_req_nx = 1'b1;
                    state_nx      = S_DRAIN;
                end else if (retire) begin
                    if (counter == SLICE_W'(1)) begin
                        if (others_valid) begin
                            switch_req_nx = 1'b1;
                            state_nx      = S_DRAIN;
                        end else begin
                            counter_nx = reload_len;
                        end
                    end else begin
                        counter_nx = counter - SLICE_W'(1);
                    end
                end
            end

            S_DRAIN: begin
                if (switch_ack) begin
                    // killed slot keeps its old PC
                    pc_wb         = valid[proc_index] && !kill_cur;
                    switch_req_nx = 1'b0;
                    state_nx      = S_SELECT;
                end
            end

            S_SELECT: begin
                if (next_found) begin
                    pidx_nx        = next_idx;
                    pseg_nx        = seg_tbl[next_idx];
                    ppc_nx         = pc_tbl[next_idx];
                    switch_done_nx = 1'b1;
                    counter_nx     = reload_len;
                    run_nx         = 1'b1;
                    state_nx       = S_RUN;
                end else begin
                    run_nx   = 1'b0;
                    state_nx = S_IDLE;
                end
            end

            S_IDLE: begin
                run_nx        = 1'b0;
                switch_req_nx = 1'b0;
                if (|valid) begin
                    state_nx = S_SELECT;
                end
            end

            default: begin
                state_nx = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            valid        <= NPROC'(1);
            for (int unsigned i = 0; i < NPROC; i++) begin
                seg_tbl[i] <= '0;
                pc_tbl[i]  <= '0;
            end
            counter      <= SLICE_W'(SLICE_DEFAULT);
            switch_req   <= 1'b0;
            switch_done  <= 1'b0;
            run          <= 1'b1;
            proc_index   <= '0;
            proc_segment <= '0;
            proc_pc      <= '0;
            create_ack   <= 1'b0;
            create_fail  <= 1'b0;
            create_idx   <= '0;
        end else begin
            // kill and create may land in the same cycle; they always hit
            // different slots since create only takes currently invalid ones
            if (kill_hit) begin
                valid[kill_idx] <= 1'b0;
            end
            if (create_req && free_found) begin
                valid[free_idx]   <= 1'b1;
                seg_tbl[free_idx] <= create_segment;
                pc_tbl[free_idx]  <= create_pc;
            end
            if (pc_wb) begin
                pc_tbl[proc_index] <= saved_pc;
            end
            counter      <= counter_nx;
            switch_req   <= switch_req_nx;
            switch_done  <= switch_done_nx;
            run          <= run_nx;
            proc_index   <= pidx_nx;
            proc_segment <= pseg_nx;
            proc_pc      <= ppc_nx;
            create_ack   <= create_ack_nx;
            create_fail  <= create_fail_nx;
            create_idx   <= create_idx_nx;
        end
    end

endmodule

// File: tb/tb_proc_scheduler.sv
module tb_proc_scheduler;

    localparam int NPROC   = 8;
    localparam int IDX_W   = 3;
    localparam int SLICE_W = 8;

    logic               clka = 1'b0;
    logic               rst;
    logic [SLICE_W-1:0] slice_len;
    logic               retire;
    logic               create_req;
    logic [15:0]        create_segment;
    logic [9:0]         create_pc;
    logic               create_ack;
    logic               create_fail;
    logic [IDX_W-1:0]   create_idx;
    logic               kill_req;
    logic [IDX_W-1:0]   kill_idx;
    logic               switch_req;
    logic               switch_ack;
    logic [9:0]         saved_pc;
    logic               switch_done;
    logic [IDX_W-1:0]   proc_index;
    logic [15:0]        proc_segment;
    logic [9:0]         proc_pc;
    logic               run;

    always #5 clka = ~clka;

    proc_scheduler #(
        .NPROC        (NPROC),
        .IDX_W        (IDX_W),
        .SLICE_W      (SLICE_W),
        .SLICE_DEFAULT(16)
    ) dut (
        .clka          (clka),
        .rst           (rst),
        .slice_len     (slice_len),
        .retire        (retire),
        .create_req    (create_req),
        .create_segment(create_segment),
        .create_pc     (create_pc),
        .create_ack    (create_ack),
        .create_fail   (create_fail),
        .create_idx    (create_idx),
        .kill_req      (kill_req),
        .kill_idx      (kill_idx),
        .switch_req    (switch_req),
        .switch_ack    (switch_ack),
        .saved_pc      (saved_pc),
        .switch_done   (switch_done),
        .proc_index    (proc_index),
        .proc_segment  (proc_segment),
        .proc_pc       (proc_pc),
        .run           (run)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard entries
    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [15:0]      seg;
        logic [9:0]       pc;
    } sw_t;

    typedef struct {
        bit               ok;
        logic [IDX_W-1:0] idx;
    } cr_t;

    sw_t sw_q[$];
    cr_t cr_q[$];
    sw_t se;
    cr_t ce;

    // reference model of the process table and scheduler
    logic [NPROC-1:0] m_valid;
    logic [15:0]      m_seg [NPROC];
    logic [9:0]       m_pc  [NPROC];
    int               m_idx;
    int               m_cnt;
    bit               m_drain;
    bit               m_run;
    int               m_cidx;

    function automatic int eff_len();
        return (slice_len == '0) ? 1 : int'(slice_len);
    endfunction

    function automatic bit others_valid();
        for (int i = 0; i < NPROC; i++)
            if (i != m_idx && m_valid[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int rr_next();
        int n;
        n = -1;
        for (int i = 1; i <= NPROC; i++) begin
            int j;
            j = (m_idx + i) % NPROC;
            if (n < 0 && m_valid[j]) n = j;
        end
        return n;
    endfunction

    task automatic reset_model();
        m_valid = '0;
        m_valid[0] = 1'b1;
        for (int i = 0; i < NPROC; i++) begin
            m_seg[i] = '0;
            m_pc[i]  = '0;
        end
        m_idx   = 0;
        m_cnt   = 16;
        m_drain = 1'b0;
        m_run   = 1'b1;
        m_cidx  = 0;
        cr_q.delete();
        sw_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_switch_req"},  32'(switch_req),   0);
        check({tag, "_switch_done"}, 32'(switch_done),  0);
        check({tag, "_create_ack"},  32'(create_ack),   0);
        check({tag, "_create_fail"}, 32'(create_fail),  0);
        check({tag, "_create_idx"},  32'(create_idx),   0);
        check({tag, "_proc_index"},  32'(proc_index),   0);
        check({tag, "_proc_seg"},    32'(proc_segment), 0);
        check({tag, "_proc_pc"},     32'(proc_pc),      0);
        check({tag, "_run"},         32'(run),          1);
    endtask

    // output monitor: pops expectations when the DUT reports a result
    always @(posedge clka) begin
        #1;
        if (!rst) begin
            if (create_ack || create_fail) begin
                if (cr_q.size() == 0) begin
                    check("create_unexpected", {30'd0, create_fail, create_ack}, 0);
                end else begin
                    ce = cr_q.pop_front();
                    check("create_ack",  32'(create_ack),  32'(ce.ok));
                    check("create_fail", 32'(create_fail), 32'(!ce.ok));
                    check("create_idx",  32'(create_idx),  32'(ce.idx));
                end
            end
            if (switch_done) begin
                if (sw_q.size() == 0) begin
                    check("switch_done_unexpected", 32'(switch_done), 0);
                end else begin
                    se = sw_q.pop_front();
                    check("sw_proc_index", 32'(proc_index),   32'(se.idx));
                    check("sw_proc_seg",   32'(proc_segment), 32'(se.seg));
                    check("sw_proc_pc",    32'(proc_pc),      32'(se.pc));
                    check("sw_run",        32'(run),          1);
                end
            end
        end
    end

    // one cycle of create and/or kill, starting and ending at a negedge
    task automatic op(input bit cr, input logic [15:0] seg, input logic [9:0] pc,
                      input bit kr, input int kidx);
        int  slot;
        int  nxt;
        cr_t e;
        sw_t s;
        bit  was_idle;
        slot     = -1;
        was_idle = !m_run;
        if (cr) begin
            for (int i = 0; i < NPROC; i++)
                if (slot < 0 && !m_valid[i]) slot = i;
            if (slot >= 0) begin
                e.ok   = 1'b1;
                e.idx  = IDX_W'(slot);
                m_cidx = slot;
            end else begin
                e.ok  = 1'b0;
                e.idx = IDX_W'(m_cidx);
            end
            cr_q.push_back(e);
        end
        if (kr && m_valid[kidx]) begin
            m_valid[kidx] = 1'b0;
            if (kidx == m_idx && m_run && !m_drain) m_drain = 1'b1;
        end
        if (slot >= 0) begin
            m_valid[slot] = 1'b1;
            m_seg[slot]   = seg;
            m_pc[slot]    = pc;
        end
        create_req     = cr;
        create_segment = seg;
        create_pc      = pc;
        kill_req       = kr;
        kill_idx       = IDX_W'(kidx);
        @(negedge clka);
        create_req = 1'b0;
        kill_req   = 1'b0;
        check("switch_req_op", 32'(switch_req), 32'(m_drain));
        if (was_idle && (m_valid != '0)) begin
            nxt   = rr_next();
            s.idx = IDX_W'(nxt);
            s.seg = m_seg[nxt];
            s.pc  = m_pc[nxt];
            sw_q.push_back(s);
            m_idx = nxt;
            m_cnt = eff_len();
            m_run = 1'b1;
            repeat (2) @(negedge clka);
            check("idle_wake_pending", 32'(sw_q.size()), 0);
            check("idle_wake_run",     32'(run),         1);
        end
    endtask

    task automatic do_retire(input int n);
        for (int k = 0; k < n; k++) begin
            retire = 1'b1;
            if (m_run && !m_drain) begin
                if (m_cnt == 1) begin
                    if (others_valid()) m_drain = 1'b1;
                    else m_cnt = eff_len();
                end else begin
                    m_cnt--;
                end
            end
            @(negedge clka);
            retire = 1'b0;
            check("switch_req_retire", 32'(switch_req), 32'(m_drain));
            check("proc_index_retire", 32'(proc_index), 32'(m_idx));
            check("run_retire",        32'(run),        32'(m_run));
        end
    endtask

    task automatic run_to_switch();
        int k;
        k = 0;
        while (!m_drain && k < 300) begin
            do_retire(1);
            k++;
        end
        check("switch_req_raised", 32'(switch_req), 1);
    endtask

    task automatic do_ack(input logic [9:0] spc);
        int  nxt;
        int  cnt;
        sw_t s;
        check("switch_req_before_ack", 32'(switch_req), 1);
        switch_ack = 1'b1;
        saved_pc   = spc;
        if (m_valid[m_idx]) m_pc[m_idx] = spc;
        m_drain = 1'b0;
        nxt = rr_next();
        if (nxt >= 0) begin
            s.idx = IDX_W'(nxt);
            s.seg = m_seg[nxt];
            s.pc  = m_pc[nxt];
            sw_q.push_back(s);
            m_idx = nxt;
            m_cnt = eff_len();
        end else begin
            m_run = 1'b0;
        end
        @(negedge clka);
        switch_ack = 1'b0;
        cnt = 1;
        while (!switch_done && cnt < 6) begin
            @(negedge clka);
            cnt++;
        end
        if (nxt >= 0) begin
            check("switch_latency", 32'(cnt), 2);
        end else begin
            check("idle_run",        32'(run),         0);
            check("idle_switch_req", 32'(switch_req),  0);
            check("idle_done",       32'(switch_done), 0);
            check("idle_hold_index", 32'(proc_index),  32'(m_idx));
        end
        check("switch_req_after_ack", 32'(switch_req), 0);
    endtask

    task automatic stray_ack();
        switch_ack = 1'b1;
        saved_pc   = 10'h2AA;
        @(negedge clka);
        switch_ack = 1'b0;
        @(negedge clka);
        check("stray_ack_req",   32'(switch_req),  0);
        check("stray_ack_done",  32'(switch_done), 0);
        check("stray_ack_index", 32'(proc_index),  32'(m_idx));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        slice_len      = 8'd3;
        retire         = 1'b0;
        create_req     = 1'b0;
        create_segment = '0;
        create_pc      = '0;
        kill_req       = 1'b0;
        kill_idx       = '0;
        switch_ack     = 1'b0;
        saved_pc       = '0;
        reset_model();
        repeat (2) @(negedge clka);
        rst = 1'b0;
        check_reset_outputs("reset");

        // single process: counter expires (16 after reset, then reload to 3)
        // with nobody else valid -> no switch
        do_retire(18);

        // second process, round trip 0 -> 1 -> 0
        op(1'b1, 16'h0040, 10'h010, 1'b0, 0);
        run_to_switch();
        do_ack(10'h022);
        run_to_switch();
        do_ack(10'h111);
        check("back_to_0_pc", 32'(proc_pc), 32'h022);

        // fill table, overflow, kill+create same cycle, then reuse
        for (int i = 2; i < NPROC; i++)
            op(1'b1, 16'(16'h0100 + i), 10'(10'h020 + i), 1'b0, 0);
        op(1'b1, 16'h0BAD, 10'h0BD, 1'b0, 0);
        op(1'b1, 16'h0BEE, 10'h0BE, 1'b1, 4);
        op(1'b1, 16'h0444, 10'h044, 1'b0, 0);
        stray_ack();

        // run slot 2, kill it mid-slice
        run_to_switch();
        do_ack(10'h033);
        run_to_switch();
        do_ack(10'h044);
        check("running_slot2", 32'(proc_index), 2);
        do_retire(1);
        op(1'b0, '0, '0, 1'b1, 2);
        do_ack(10'h3FF);

        // kill everything, non-running slots first
        for (int i = 0; i < NPROC; i++)
            if (i != m_idx) op(1'b0, '0, '0, 1'b1, i);
        op(1'b0, '0, '0, 1'b1, m_idx);
        do_ack(10'h155);
        do_retire(1);

        // wake from idle
        op(1'b1, 16'h0005, 10'h000, 1'b0, 0);
        check("wake_seg", 32'(proc_segment), 32'h0005);

        // async reset while draining
        op(1'b1, 16'h0077, 10'h077, 1'b0, 0);
        run_to_switch();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clka);
        rst = 1'b0;
        reset_model();
        check_reset_outputs("post_reset");
        op(1'b1, 16'h0099, 10'h099, 1'b0, 0);
        @(negedge clka);

        check("create_q_empty", 32'(cr_q.size()), 0);
        check("switch_q_empty", 32'(sw_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
